tennis_rally_controller: RTL and testbench
==========================================

Name: tennis_rally_controller

Overview:
- Game-control core of the two-player FPGA pong/tennis game.
- Turns player buttons, zone switches and the ball-position vector into ball commands: halt, direction, speed, reset and serve side.
- Keeps tennis scoring: 0/15/30/40, deuce/advantage, and game point (encoded 45).
- Sits between the board I/O (switches, buttons) and the ball-motion and display blocks.

Parameters:
COOLDOWN, 50000000, clock cycles a player's button is ignored after a swing.
SCORE_W, 16, width of each score output.

Ports:
clk  in  1  system clock, all state changes on its rising edge.
rst_n  in  1  asynchronous active-low reset.
sw  in  10  zone enables; sw[4:0] belong to P1, sw[9:5] to P2.
p1_btn  in  1  P1 swing button, level, active-high.
p2_btn  in  1  P2 swing button, level, active-high.
ctrl  in  1  new-game request, honoured only after a game is won.
position  in  10  one-hot ball position; bit 0 is the P1 end, bit 9 the P2 end.
outside  in  1  ball has left the court (level, from ball block).
winner  in  1  point winner while outside is high: 1 = P1, 0 = P2.
speed  out  2  ball speed = power of last successful hitter.
direction  out  1  0 = ball travels toward P2, 1 = toward P1.
halt  out  1  1 = ball frozen.
rstball  out  1  1 = ball block returns the ball to the serve position.
ball  out  1  serving side: 1 = P1, 0 = P2.
p1_score  out  SCORE_W  P1 points, one of 0/15/30/40/45.
p2_score  out  SCORE_W  P2 points, one of 0/15/30/40/45.
p1_deuce  out  1  P1 holds advantage.
p2_deuce  out  1  P2 holds advantage.

Behaviour:
- Reset values:
  - halt=1, direction=0, ball=1, rstball=0, speed=0.
  - Both scores 0, both advantage flags 0.
  - Both players ready, cooldown counters 0, powers 0, last-hitter select = P1.
- Out handling (highest priority):
  - Every cycle outside=1: halt=1, rstball=1, hits ignored.
  - On the rising edge of outside (registered outside_d), exactly one point is scored for the winner.
  - Winner P1: ball=1, direction=0. Winner P2: ball=0, direction=1.
- Point award for player X against opponent Y:
  - Ladder 0->15->30->40.
  - At 40 with Y below 40: X=45, game won.
  - At 40 with Y=40: if Y holds advantage, clear Y's advantage. Else if X holds advantage, X=45. Else set X's advantage.
  - Scores never change while either score is 45.
- Idle cycles (outside=0):
  - rstball=0, except the new-game pulse below.
  - If either score is 45 and ctrl=1: one-cycle new-game pulse. Scores and advantages cleared, direction=0, ball=1, halt=1, rstball=1.
- Swing (per player, independent):
  - A swing starts when the player is ready, presses the button, outside=0, and no score is 45.
  - Start: ready cleared, counter loaded with COOLDOWN-1.
  - Each cycle while not ready, the counter decrements. At 0, ready is set (cooldown = COOLDOWN cycles).
  - Button level is ignored while not ready.
- Zone/power, computed in the swing cycle:
  - Scan the player's 5 sw bits lowest index first. The first up to 3 set bits become active zone bits.
  - power = number of active bits (0..3).
- Hit:
  - A hit occurs if position AND active zone is nonzero.
  - If halt=1, only the serving side (ball) may hit.
  - On hit: halt=0, select := hitter, direction = 0 for P1 and 1 for P2.
  - A miss changes nothing but still consumes the cooldown.
- Simultaneous swings in one cycle: P2 is evaluated last and wins direction/select if both hit.
- speed: combinational mux of the selected hitter's registered power.
- Reset asserted mid-operation immediately forces all reset values.

Decomposition:
- Shared package:
  - Score constants PTS_0=0, PTS_15=15, PTS_30=30, PTS_40=40, PTS_GAME=45.
  - DIR_TO_P2=0, DIR_TO_P1=1.
  - SIDE_P1=1.
- One natural sub-module, player_swing, instantiated twice. It holds the ready flag, cooldown counter, zone/power extraction, and hit detection, and outputs a hit strobe and power.
- Scoring and ball control stay in the top.

Test Plan:
- Reset, then COOLDOWN=4: outputs halt=1, ball=1, dir=0, scores 0. sw=10'b0000000111, position=1, p1_btn pulse -> halt=0, direction=0, speed=3.
- sw[9:5]=5'b00011, position bit 5, p2_btn held 10 cycles -> exactly 2 swings (cooldown 4), first hits: direction=1, speed=2.
- Four outside pulses with winner=1 -> p1_score 15,30,40,45, ball=1, rstball high during each pulse. Further pulses leave scores at 45. ctrl=1 -> all zero, rstball 1-cycle pulse.
- Reach 40-40. P1 wins -> p1_deuce=1. P2 wins -> p1_deuce=0. P2 wins -> p2_deuce=1. P2 wins -> p2_score=45.
- outside held high 20 cycles -> exactly one point scored. Button press during it -> halt stays 1.
- While halt=1 and ball=1, P2 presses with position in P2's zone -> no hit, halt stays 1, P2 still goes into cooldown.

Source files
------------

// File: rtl/tennis_rally_controller_pkg.sv
// Shared constants, types and helpers for the tennis rally controller.
package tennis_rally_controller_pkg;

  typedef logic [5:0] pts_t;

  localparam pts_t PTS_0    = 6'd0;
  localparam pts_t PTS_15   = 6'd15;
  localparam pts_t PTS_30   = 6'd30;
  localparam pts_t PTS_40   = 6'd40;
  localparam pts_t PTS_GAME = 6'd45;

  localparam logic DIR_TO_P2 = 1'b0;
  localparam logic DIR_TO_P1 = 1'b1;
  localparam logic SIDE_P1   = 1'b1;
  localparam logic SIDE_P2   = 1'b0;

  typedef enum logic {SEL_P1 = 1'b0, SEL_P2 = 1'b1} hitter_e;

  typedef struct packed {
    pts_t x_pts;
    logic x_adv;
    logic y_adv;
  } award_t;

  // Keep the first (lowest index) three enabled zone switches.
  function automatic logic [4:0] zone_pick(input logic [4:0] sw);
    logic [4:0] z;
    int unsigned n;
    z = '0;
    n = 0;
    for (int i = 0; i < 5; i++) begin
      if (sw[i] && n < 3) begin
        z[i] = 1'b1;
        n++;
      end
    end
    return z;
  endfunction

  // Power is the number of active zone bits (at most three).
  function automatic logic [1:0] zone_power(input logic [4:0] z);
    logic [1:0] p;
    p = '0;
    for (int i = 0; i < 5; i++) begin
      if (z[i]) p = p + 2'd1;
    end
    return p;
  endfunction

  // One point to player X against opponent Y, including deuce/advantage.
  function automatic award_t award_point(input pts_t x, input pts_t y,
                                         input logic x_adv, input logic y_adv);
    award_t r;
    r.x_pts = x;
    r.x_adv = x_adv;
    r.y_adv = y_adv;
    case (x)
      PTS_0:  r.x_pts = PTS_15;
      PTS_15: r.x_pts = PTS_30;
      PTS_30: r.x_pts = PTS_40;
      PTS_40: begin
        if (y != PTS_40)  r.x_pts = PTS_GAME;
        else if (y_adv)   r.y_adv = 1'b0;
        else if (x_adv)   r.x_pts = PTS_GAME;
        else              r.x_adv = 1'b1;
      end
      default: ;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/tennis_rally_controller_if.sv
// Board-side bundle: switches, buttons, ball status in; ball commands and score out.
interface tennis_rally_controller_if #(parameter int SCORE_W = 16);
  logic [9:0]         sw;
  logic               p1_btn;
  logic               p2_btn;
  logic               ctrl;
  logic [9:0]         position;
  logic               outside;
  logic               winner;
  logic [1:0]         speed;
  logic               direction;
  logic               halt;
  logic               rstball;
  logic               ball;
  logic [SCORE_W-1:0] p1_score;
  logic [SCORE_W-1:0] p2_score;
  logic               p1_deuce;
  logic               p2_deuce;

  modport master (
    output sw, p1_btn, p2_btn, ctrl, position, outside, winner,
    input  speed, direction, halt, rstball, ball, p1_score, p2_score, p1_deuce, p2_deuce
  );

  modport slave (
    input  sw, p1_btn, p2_btn, ctrl, position, outside, winner,
    output speed, direction, halt, rstball, ball, p1_score, p2_score, p1_deuce, p2_deuce
  );
endinterface

// File: rtl/tennis_rally_controller_player_swing.sv
// One player's racket: swing cooldown, zone/power extraction and hit detection.
module player_swing
  import tennis_rally_controller_pkg::*;
#(
  parameter int COOLDOWN = 50000000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       btn_i,
  input  logic       outside_i,
  input  logic       game_over_i,
  input  logic       allow_i,
  input  logic [4:0] zone_sw_i,
  input  logic [4:0] pos_i,
  output logic       hit_o,
  output logic [1:0] power_o,
  output logic       ready_o
);

  localparam int CNT_W = (COOLDOWN > 1) ? $clog2(COOLDOWN) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(COOLDOWN - 1);

  logic             ready_q, ready_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       pow_q, pow_d;
  logic [4:0]       zone;
  logic             swing;

  // Swing decode, hit test and cooldown down-counter next state.
  always_comb begin
    ready_d = ready_q;
    cnt_d   = cnt_q;
    pow_d   = pow_q;
    zone    = zone_pick(zone_sw_i);
    swing   = ready_q & btn_i & ~outside_i & ~game_over_i;
    hit_o   = swing & allow_i & (|(pos_i & zone));
    if (swing) begin
      ready_d = 1'b0;
      cnt_d   = CNT_LOAD;
      // speed reflects the last successful hit, so misses leave power alone
      if (hit_o) pow_d = zone_power(zone);
    end else if (!ready_q) begin
      if (cnt_q == '0) ready_d = 1'b1;
      else             cnt_d   = cnt_q - 1'b1;
    end
  end

  // State registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ready_q <= 1'b1;
      cnt_q   <= '0;
      pow_q   <= '0;
    end else begin
      ready_q <= ready_d;
      cnt_q   <= cnt_d;
      pow_q   <= pow_d;
    end
  end

  assign power_o = pow_q;
  assign ready_o = ready_q;

endmodule

// File: rtl/tennis_rally_controller.sv
// Pong/tennis game core: ball commands from swings, tennis scoring from outs.
module tennis_rally_controller
  import tennis_rally_controller_pkg::*;
#(
  parameter int COOLDOWN = 50000000,
  parameter int SCORE_W  = 16
) (
  input logic                    clk,
  input logic                    rst_n,
  tennis_rally_controller_if.slave bus
);

  logic    halt_q, halt_d;
  logic    dir_q, dir_d;
  logic    ball_q, ball_d;
  logic    rstball_q, rstball_d;
  logic    outside_q;
  pts_t    p1_pts_q, p1_pts_d, p2_pts_q, p2_pts_d;
  logic    p1_adv_q, p1_adv_d, p2_adv_q, p2_adv_d;
  hitter_e sel_q, sel_d;

  logic       game_over;
  logic       p1_hit, p2_hit;
  logic [1:0] p1_pow, p2_pow;
  logic       p1_ready, p2_ready;
  award_t     aw_p1, aw_p2;

  assign game_over = (p1_pts_q == PTS_GAME) || (p2_pts_q == PTS_GAME);
  assign aw_p1     = award_point(p1_pts_q, p2_pts_q, p1_adv_q, p2_adv_q);
  assign aw_p2     = award_point(p2_pts_q, p1_pts_q, p2_adv_q, p1_adv_q);

  player_swing #(.COOLDOWN(COOLDOWN)) u_p1 (
    .clk        (clk),
    .rst_n      (rst_n),
    .btn_i      (bus.p1_btn),
    .outside_i  (bus.outside),
    .game_over_i(game_over),
    .allow_i    (!halt_q || ball_q == SIDE_P1),
    .zone_sw_i  (bus.sw[4:0]),
    .pos_i      (bus.position[4:0]),
    .hit_o      (p1_hit),
    .power_o    (p1_pow),
    .ready_o    (p1_ready)
  );

  player_swing #(.COOLDOWN(COOLDOWN)) u_p2 (
    .clk        (clk),
    .rst_n      (rst_n),
    .btn_i      (bus.p2_btn),
    .outside_i  (bus.outside),
    .game_over_i(game_over),
    .allow_i    (!halt_q || ball_q == SIDE_P2),
    .zone_sw_i  (bus.sw[9:5]),
    .pos_i      (bus.position[9:5]),
    .hit_o      (p2_hit),
    .power_o    (p2_pow),
    .ready_o    (p2_ready)
  );

  // Out handling first, then new-game request, then hits (P2 applied last).
  always_comb begin
    halt_d    = halt_q;
    dir_d     = dir_q;
    ball_d    = ball_q;
    rstball_d = 1'b0;
    p1_pts_d  = p1_pts_q;
    p2_pts_d  = p2_pts_q;
    p1_adv_d  = p1_adv_q;
    p2_adv_d  = p2_adv_q;
    sel_d     = sel_q;
    if (bus.outside) begin
      halt_d    = 1'b1;
      rstball_d = 1'b1;
      if (!outside_q) begin
        if (bus.winner) begin
          ball_d = SIDE_P1;
          dir_d  = DIR_TO_P2;
          if (!game_over) begin
            p1_pts_d = aw_p1.x_pts;
            p1_adv_d = aw_p1.x_adv;
            p2_adv_d = aw_p1.y_adv;
          end
        end else begin
          ball_d = SIDE_P2;
          dir_d  = DIR_TO_P1;
          if (!game_over) begin
            p2_pts_d = aw_p2.x_pts;
            p2_adv_d = aw_p2.x_adv;
            p1_adv_d = aw_p2.y_adv;
          end
        end
      end
    end else if (game_over && bus.ctrl) begin
      p1_pts_d  = PTS_0;
      p2_pts_d  = PTS_0;
      p1_adv_d  = 1'b0;
      p2_adv_d  = 1'b0;
      dir_d     = DIR_TO_P2;
      ball_d    = SIDE_P1;
      halt_d    = 1'b1;
      rstball_d = 1'b1;
    end else begin
      if (p1_hit) begin
        halt_d = 1'b0;
        sel_d  = SEL_P1;
        dir_d  = DIR_TO_P2;
      end
      if (p2_hit) begin
        halt_d = 1'b0;
        sel_d  = SEL_P2;
        dir_d  = DIR_TO_P1;
      end
    end
  end

  // State registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      halt_q    <= 1'b1;
      dir_q     <= DIR_TO_P2;
      ball_q    <= SIDE_P1;
      rstball_q <= 1'b0;
      outside_q <= 1'b0;
      p1_pts_q  <= PTS_0;
      p2_pts_q  <= PTS_0;
      p1_adv_q  <= 1'b0;
      p2_adv_q  <= 1'b0;
      sel_q     <= SEL_P1;
    end else begin
      halt_q    <= halt_d;
      dir_q     <= dir_d;
      ball_q    <= ball_d;
      rstball_q <= rstball_d;
      outside_q <= bus.outside;
      p1_pts_q  <= p1_pts_d;
      p2_pts_q  <= p2_pts_d;
      p1_adv_q  <= p1_adv_d;
      p2_adv_q  <= p2_adv_d;
      sel_q     <= sel_d;
    end
  end

  assign bus.speed     = (sel_q == SEL_P2) ? p2_pow : p1_pow;
  assign bus.direction = dir_q;
  assign bus.halt      = halt_q;
  assign bus.rstball   = rstball_q;
  assign bus.ball      = ball_q;
  assign bus.p1_score  = SCORE_W'(p1_pts_q);
  assign bus.p2_score  = SCORE_W'(p2_pts_q);
  assign bus.p1_deuce  = p1_adv_q;
  assign bus.p2_deuce  = p2_adv_q;

endmodule

// File: tb/tb_tennis_rally_controller.sv
// Directed bench for the tennis rally controller with a short cooldown.
module tb_tennis_rally_controller;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  tennis_rally_controller_if #(.SCORE_W(16)) bus ();

  tennis_rally_controller #(.COOLDOWN(4), .SCORE_W(16)) u_dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic point(input logic w);
    bus.outside = 1'b1;
    bus.winner  = w;
    @(negedge clk);
    bus.outside = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.sw = '0; bus.p1_btn = 0; bus.p2_btn = 0; bus.ctrl = 0;
    bus.position = '0; bus.outside = 0; bus.winner = 0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++; if (bus.halt !== 1'b1) begin errors++; $display("FAIL reset_halt got %0b exp 1", bus.halt); end
    checks++; if (bus.ball !== 1'b1) begin errors++; $display("FAIL reset_ball got %0b exp 1", bus.ball); end
    checks++; if (bus.direction !== 1'b0) begin errors++; $display("FAIL reset_dir got %0b exp 0", bus.direction); end
    checks++; if (bus.rstball !== 1'b0) begin errors++; $display("FAIL reset_rstball got %0b exp 0", bus.rstball); end
    checks++; if (bus.speed !== 2'd0) begin errors++; $display("FAIL reset_speed got %0d exp 0", bus.speed); end
    checks++; if (bus.p1_score !== 16'd0 || bus.p2_score !== 16'd0) begin errors++; $display("FAIL reset_scores got %0d/%0d exp 0/0", bus.p1_score, bus.p2_score); end
    checks++; if (bus.p1_deuce !== 1'b0 || bus.p2_deuce !== 1'b0) begin errors++; $display("FAIL reset_adv got %0b/%0b exp 0/0", bus.p1_deuce, bus.p2_deuce); end
  endtask

  task automatic test_p1_serve();
    bus.sw = 10'b0000000111;
    bus.position = 10'b0000000001;
    bus.p1_btn = 1'b1;
    @(negedge clk);
    bus.p1_btn = 1'b0;
    checks++; if (bus.halt !== 1'b0) begin errors++; $display("FAIL serve_halt got %0b exp 0", bus.halt); end
    checks++; if (bus.direction !== 1'b0) begin errors++; $display("FAIL serve_dir got %0b exp 0", bus.direction); end
    checks++; if (bus.speed !== 2'd3) begin errors++; $display("FAIL serve_speed got %0d exp 3", bus.speed); end
    repeat (6) @(negedge clk);
  endtask

  task automatic test_p2_cooldown();
    int   swings;
    logic prev;
    swings = 0;
    bus.sw = 10'b0001100111;
    bus.position = 10'b0000100000;
    prev = u_dut.u_p2.ready_o;
    bus.p2_btn = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (i == 0) begin
        checks++; if (bus.direction !== 1'b1) begin errors++; $display("FAIL p2hit_dir got %0b exp 1", bus.direction); end
        checks++; if (bus.speed !== 2'd2) begin errors++; $display("FAIL p2hit_speed got %0d exp 2", bus.speed); end
      end
      if (prev && !u_dut.u_p2.ready_o) swings++;
      prev = u_dut.u_p2.ready_o;
    end
    bus.p2_btn = 1'b0;
    checks++; if (swings != 2) begin errors++; $display("FAIL p2_swing_count got %0d exp 2", swings); end
    repeat (6) @(negedge clk);
  endtask

  task automatic test_scoring();
    logic [15:0] exp_pts [4];
    exp_pts[0] = 16'd15; exp_pts[1] = 16'd30; exp_pts[2] = 16'd40; exp_pts[3] = 16'd45;
    bus.position = '0;
    for (int i = 0; i < 6; i++) begin
      bus.outside = 1'b1;
      bus.winner  = 1'b1;
      @(negedge clk);
      checks++; if (bus.rstball !== 1'b1 || bus.halt !== 1'b1) begin errors++; $display("FAIL score_out%0d rstball/halt got %0b/%0b exp 1/1", i, bus.rstball, bus.halt); end
      checks++; if (bus.p1_score !== exp_pts[(i > 3) ? 3 : i]) begin errors++; $display("FAIL score_p1_%0d got %0d exp %0d", i, bus.p1_score, exp_pts[(i > 3) ? 3 : i]); end
      bus.outside = 1'b0;
      @(negedge clk);
      checks++; if (bus.ball !== 1'b1 || bus.direction !== 1'b0 || bus.rstball !== 1'b0) begin errors++; $display("FAIL score_after%0d ball/dir/rstball got %0b/%0b/%0b exp 1/0/0", i, bus.ball, bus.direction, bus.rstball); end
    end
    checks++; if (bus.p2_score !== 16'd0) begin errors++; $display("FAIL score_p2 got %0d exp 0", bus.p2_score); end
    bus.ctrl = 1'b1;
    @(negedge clk);
    bus.ctrl = 1'b0;
    checks++; if (bus.rstball !== 1'b1) begin errors++; $display("FAIL newgame_rstball got %0b exp 1", bus.rstball); end
    checks++; if (bus.p1_score !== 16'd0 || bus.p2_score !== 16'd0) begin errors++; $display("FAIL newgame_scores got %0d/%0d exp 0/0", bus.p1_score, bus.p2_score); end
    checks++; if (bus.halt !== 1'b1 || bus.ball !== 1'b1 || bus.direction !== 1'b0) begin errors++; $display("FAIL newgame_ball got halt %0b ball %0b dir %0b exp 1/1/0", bus.halt, bus.ball, bus.direction); end
    @(negedge clk);
    checks++; if (bus.rstball !== 1'b0) begin errors++; $display("FAIL newgame_pulse got %0b exp 0", bus.rstball); end
  endtask

  task automatic test_deuce();
    repeat (3) point(1'b1);
    repeat (3) point(1'b0);
    checks++; if (bus.p1_score !== 16'd40 || bus.p2_score !== 16'd40) begin errors++; $display("FAIL deuce_40_40 got %0d/%0d exp 40/40", bus.p1_score, bus.p2_score); end
    point(1'b1);
    checks++; if (bus.p1_deuce !== 1'b1 || bus.p1_score !== 16'd40) begin errors++; $display("FAIL adv_p1 got adv %0b pts %0d exp 1/40", bus.p1_deuce, bus.p1_score); end
    point(1'b0);
    checks++; if (bus.p1_deuce !== 1'b0 || bus.p2_deuce !== 1'b0) begin errors++; $display("FAIL adv_clear got %0b/%0b exp 0/0", bus.p1_deuce, bus.p2_deuce); end
    point(1'b0);
    checks++; if (bus.p2_deuce !== 1'b1) begin errors++; $display("FAIL adv_p2 got %0b exp 1", bus.p2_deuce); end
    point(1'b0);
    checks++; if (bus.p2_score !== 16'd45 || bus.p1_score !== 16'd40) begin errors++; $display("FAIL game_p2 got %0d/%0d exp 40/45", bus.p1_score, bus.p2_score); end
    bus.ctrl = 1'b1;
    @(negedge clk);
    bus.ctrl = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_outside_held();
    bus.sw = 10'b0000000111;
    bus.position = 10'b0000000001;
    bus.outside = 1'b1;
    bus.winner  = 1'b0;
    for (int i = 0; i < 20; i++) begin
      bus.p1_btn = (i >= 5 && i < 8);
      @(negedge clk);
    end
    bus.p1_btn = 1'b0;
    checks++; if (bus.p2_score !== 16'd15 || bus.p1_score !== 16'd0) begin errors++; $display("FAIL held_one_point got %0d/%0d exp 0/15", bus.p1_score, bus.p2_score); end
    checks++; if (bus.halt !== 1'b1 || bus.rstball !== 1'b1) begin errors++; $display("FAIL held_halt got %0b/%0b exp 1/1", bus.halt, bus.rstball); end
    checks++; if (u_dut.u_p1.ready_o !== 1'b1) begin errors++; $display("FAIL held_no_swing ready got %0b exp 1", u_dut.u_p1.ready_o); end
    bus.outside = 1'b0;
    @(negedge clk);
    checks++; if (bus.ball !== 1'b0 || bus.direction !== 1'b1 || bus.rstball !== 1'b0) begin errors++; $display("FAIL held_after ball/dir/rstball got %0b/%0b/%0b exp 0/1/0", bus.ball, bus.direction, bus.rstball); end
  endtask

  task automatic test_serve_side();
    point(1'b1);
    bus.sw = 10'b0001100111;
    bus.position = 10'b0000100000;
    bus.p2_btn = 1'b1;
    @(negedge clk);
    bus.p2_btn = 1'b0;
    checks++; if (bus.halt !== 1'b1) begin errors++; $display("FAIL wrong_side_halt got %0b exp 1", bus.halt); end
    checks++; if (u_dut.u_p2.ready_o !== 1'b0) begin errors++; $display("FAIL wrong_side_cooldown ready got %0b exp 0", u_dut.u_p2.ready_o); end
    repeat (6) @(negedge clk);
    bus.position = 10'b0000000100;
    bus.p1_btn = 1'b1;
    @(negedge clk);
    bus.p1_btn = 1'b0;
    checks++; if (bus.halt !== 1'b0 || bus.direction !== 1'b0 || bus.speed !== 2'd3) begin errors++; $display("FAIL p1_serve2 halt/dir/speed got %0b/%0b/%0d exp 0/0/3", bus.halt, bus.direction, bus.speed); end
  endtask

  task automatic test_reset_mid();
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (bus.halt !== 1'b1 || bus.speed !== 2'd0 || bus.ball !== 1'b1) begin errors++; $display("FAIL midreset halt/speed/ball got %0b/%0d/%0b exp 1/0/1", bus.halt, bus.speed, bus.ball); end
    checks++; if (bus.p1_score !== 16'd0 || bus.p2_score !== 16'd0) begin errors++; $display("FAIL midreset_scores got %0d/%0d exp 0/0", bus.p1_score, bus.p2_score); end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_p1_serve();
    test_p2_cooldown();
    test_scoring();
    test_deuce();
    test_outside_held();
    test_serve_side();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
